// File: rtl/ha_resp_checker_if.sv
// Checker bus: session control, one vector plus DUT response per valid cycle, and verdict/status.
// No backpressure: the checker accepts a vector on every valid cycle while running.
interface ha_resp_checker_if #(
  parameter int ERR_W = 4,
  parameter int VEC_W = 8
);
  logic             start;
  logic             valid;
  logic             last;
  logic             a;
  logic             b;
  logic             c;
  logic             s;
  logic             busy;
  logic             mismatch;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [VEC_W-1:0] vec_count;
  logic [3:0]       covered;
  logic [1:0]       first_err;

  modport master (
    output start, valid, last, a, b, c, s,
    input  busy, mismatch, done, pass, err_count, vec_count, covered, first_err
  );

  modport slave (
    input  start, valid, last, a, b, c, s,
    output busy, mismatch, done, pass, err_count, vec_count, covered, first_err
  );
endinterface

// File: rtl/ha_resp_checker.sv
// Half-adder response checker: IDLE/RUN/DONE session, counts, coverage bitmap, first failure.
// Mismatch pulses one cycle after a bad vector; never stalls, vectors outside RUN are dropped.
module ha_resp_checker #(
  parameter int ERR_W = 4,
  parameter int VEC_W = 8
) (
  input logic             clk,
  input logic             rst,
  ha_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [VEC_W-1:0] vec_count_q, vec_count_d;
  logic [3:0]       covered_q, covered_d;
  logic [1:0]       first_err_q, first_err_d;
  logic             err_seen_q, err_seen_d;
  logic             mismatch_q, mismatch_d;

  logic [1:0] vec_ab;
  logic       exp_c;
  logic       exp_s;
  logic       vec_fail;

  assign vec_ab   = {bus.a, bus.b};
  assign exp_c    = bus.a & bus.b;
  assign exp_s    = bus.a ^ bus.b;
  assign vec_fail = (bus.c != exp_c) || (bus.s != exp_s);

  always_comb begin
    state_d     = state_q;
    err_count_d = err_count_q;
    vec_count_d = vec_count_q;
    covered_d   = covered_q;
    first_err_d = first_err_q;
    err_seen_d  = err_seen_q;
    mismatch_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          err_count_d = '0;
          vec_count_d = '0;
          covered_d   = '0;
          first_err_d = '0;
          err_seen_d  = 1'b0;
        end
      end
      RUN: begin
        if (bus.valid) begin
          vec_count_d         = (vec_count_q == '1) ? vec_count_q : vec_count_q + VEC_W'(1);
          covered_d[vec_ab]   = 1'b1;
          if (vec_fail) begin
            mismatch_d  = 1'b1;
            err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + ERR_W'(1);
            // Only the first failure of a session is recorded.
            if (!err_seen_q) begin
              first_err_d = vec_ab;
              err_seen_d  = 1'b1;
            end
          end
          if (bus.last) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      err_count_q <= '0;
      vec_count_q <= '0;
      covered_q   <= '0;
      first_err_q <= '0;
      err_seen_q  <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      err_count_q <= err_count_d;
      vec_count_q <= vec_count_d;
      covered_q   <= covered_d;
      first_err_q <= first_err_d;
      err_seen_q  <= err_seen_d;
      mismatch_q  <= mismatch_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == DONE);
  assign bus.pass      = (state_q == DONE) && (err_count_q == '0) && (covered_q == 4'b1111);
  assign bus.mismatch  = mismatch_q;
  assign bus.err_count = err_count_q;
  assign bus.vec_count = vec_count_q;
  assign bus.covered   = covered_q;
  assign bus.first_err = first_err_q;

endmodule

// File: tb/tb_ha_resp_checker.sv
// Directed bench: per-cycle vector table on the default-width checker, plus a saturation
// sequence on a narrow-counter instance.
module tb_ha_resp_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ha_resp_checker_if #(.ERR_W(4), .VEC_W(8)) bus0 ();
  ha_resp_checker_if #(.ERR_W(2), .VEC_W(3)) bus1 ();

  ha_resp_checker #(.ERR_W(4), .VEC_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  ha_resp_checker #(.ERR_W(2), .VEC_W(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // inp = {rst, start, valid, last, a, b, c, s}
  // exp = {busy, mismatch, done, pass, err[3:0], vec[7:0], covered[3:0], first_err[1:0]}
  typedef struct {
    logic [7:0]  inp;
    logic [21:0] exp;
  } row_t;

  row_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic logic [21:0] obs(input int busy, input int mm, input int dn, input int ps,
                                      input int err, input int vec, input logic [3:0] cov,
                                      input logic [1:0] ferr);
    return {1'(busy), 1'(mm), 1'(dn), 1'(ps), 4'(err), 8'(vec), cov, ferr};
  endfunction

  function automatic void add(input logic [7:0] inp, input logic [21:0] exp);
    row_t r;
    r.inp = inp;
    r.exp = exp;
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive1(input logic st, input logic v, input logic l,
                        input logic ia, input logic ib, input logic ic, input logic is);
    bus1.start = st; bus1.valid = v; bus1.last = l;
    bus1.a = ia; bus1.b = ib; bus1.c = ic; bus1.s = is;
    @(posedge clk);
    #1;
  endtask

  logic [21:0] act0;

  initial begin
    rst = 1'b1;
    {bus0.start, bus0.valid, bus0.last, bus0.a, bus0.b, bus0.c, bus0.s} = '0;
    {bus1.start, bus1.valid, bus1.last, bus1.a, bus1.b, bus1.c, bus1.s} = '0;

    // reset, reset dominating start/valid/last, vectors ignored in IDLE
    add(8'b1_0_0_0_0000, obs(0,0,0,0,0,0,4'b0000,2'b00));
    add(8'b1_1_1_1_0101, obs(0,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_1100, obs(0,0,0,0,0,0,4'b0000,2'b00));
    // clean full-coverage session
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_0000, obs(1,0,0,0,0,1,4'b0001,2'b00));
    add(8'b0_0_1_0_0101, obs(1,0,0,0,0,2,4'b0011,2'b00));
    add(8'b0_0_1_0_1001, obs(1,0,0,0,0,3,4'b0111,2'b00));
    add(8'b0_0_1_1_1110, obs(0,0,1,1,0,4,4'b1111,2'b00));
    add(8'b0_0_1_1_1100, obs(0,0,1,1,0,4,4'b1111,2'b00));
    // restart from DONE; second vector bad; start during RUN ignored
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_0000, obs(1,0,0,0,0,1,4'b0001,2'b00));
    add(8'b0_0_1_0_0100, obs(1,1,0,0,1,2,4'b0011,2'b01));
    add(8'b0_1_1_0_1001, obs(1,0,0,0,1,3,4'b0111,2'b01));
    add(8'b0_0_1_1_1110, obs(0,0,1,0,1,4,4'b1111,2'b01));
    add(8'b0_0_0_0_0000, obs(0,0,1,0,1,4,4'b1111,2'b01));
    // restart after failing session clears everything; partial coverage; last without valid
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_0000, obs(1,0,0,0,0,1,4'b0001,2'b00));
    add(8'b0_0_0_1_1110, obs(1,0,0,0,0,1,4'b0001,2'b00));
    add(8'b0_0_1_1_1110, obs(0,0,1,0,0,2,4'b1001,2'b00));
    // two failures: first_err keeps the first; idle cycle changes nothing
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_1100, obs(1,1,0,0,1,1,4'b1000,2'b11));
    add(8'b0_0_1_0_0010, obs(1,1,0,0,2,2,4'b1001,2'b11));
    add(8'b0_0_0_0_0000, obs(1,0,0,0,2,2,4'b1001,2'b11));
    add(8'b0_0_1_1_1001, obs(0,0,1,0,2,3,4'b1101,2'b11));
    // reset mid-RUN, then vectors without start
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_0000, obs(1,0,0,0,0,1,4'b0001,2'b00));
    add(8'b0_0_1_0_0101, obs(1,0,0,0,0,2,4'b0011,2'b00));
    add(8'b1_1_1_1_1100, obs(0,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_0_0000, obs(0,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_1_1110, obs(0,0,0,0,0,0,4'b0000,2'b00));
    // failing last vector: mismatch lands in the first DONE cycle; reset from DONE
    add(8'b0_1_0_0_0000, obs(1,0,0,0,0,0,4'b0000,2'b00));
    add(8'b0_0_1_1_0011, obs(0,1,1,0,1,1,4'b0001,2'b00));
    add(8'b0_0_0_0_0000, obs(0,0,1,0,1,1,4'b0001,2'b00));
    add(8'b1_0_0_0_0000, obs(0,0,0,0,0,0,4'b0000,2'b00));

    foreach (tbl[i]) begin
      {rst, bus0.start, bus0.valid, bus0.last, bus0.a, bus0.b, bus0.c, bus0.s} = tbl[i].inp;
      @(posedge clk);
      #1;
      act0 = {bus0.busy, bus0.mismatch, bus0.done, bus0.pass, bus0.err_count,
              bus0.vec_count, bus0.covered, bus0.first_err};
      chk($sformatf("row%0d", i), 32'(act0), 32'(tbl[i].exp));
    end
    rst = 1'b0;

    // narrow counters: ERR_W=2 saturates at 3, VEC_W=3 saturates at 7
    drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("n_busy", 32'(bus1.busy), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      drive1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk($sformatf("n_err%0d", k), 32'(bus1.err_count), (k < 3) ? 32'(k) : 32'd3);
      chk($sformatf("n_vec%0d", k), 32'(bus1.vec_count), (k < 7) ? 32'(k) : 32'd7);
      chk($sformatf("n_mm%0d", k), 32'(bus1.mismatch), 32'd1);
    end
    drive1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("n_done", {28'd0, bus1.done, bus1.pass, bus1.mismatch, bus1.busy}, 32'b1000);
    chk("n_final", {bus1.err_count, bus1.vec_count, bus1.covered, bus1.first_err}, 32'b11_111_1001_11);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ha_resp_checker.md
HA_RESP_CHECKER -- requirements
Module: ha_resp_checker

Interface
REQ-001 Parameter ERR_W, default 4, SHALL set the width of the error counter.
REQ-002 Parameter VEC_W, default 8, SHALL set the width of the vector counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL begin a check session (IDLE/DONE -> RUN).
REQ-006 valid  input  1  SHALL qualify a, b, c, s as one applied vector plus its DUT response.
REQ-007 last  input  1  SHALL mark the final vector of a session; meaningful only when valid=1.
REQ-008 a, b  input  1 each  SHALL be the stimulus bits driven to the half-adder DUT.
REQ-009 c, s  input  1 each  SHALL be the DUT carry and sum responses.
REQ-010 busy  output  1  SHALL be high while in RUN.
REQ-011 mismatch  output  1  SHALL be a one-cycle pulse flagging a failed vector.
REQ-012 done  output  1  SHALL be high while in DONE.
REQ-013 pass  output  1  SHALL be the session verdict, valid while done=1.
REQ-014 err_count  output  ERR_W  SHALL hold the failed-vector count.
REQ-015 vec_count  output  VEC_W  SHALL hold the checked-vector count.
REQ-016 covered  output  4  SHALL hold the bitmap of {a,b} combinations seen, bit index = {a,b}.
REQ-017 first_err  output  2  SHALL hold {a,b} of the first failed vector.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE.
REQ-019 IDLE: start=1 -> RUN; counters, covered, first_err, err-seen flag cleared on the same edge.
REQ-020 RUN: each cycle with valid=1 SHALL be checked against expected c=a&b, s=a^b.
REQ-021 RUN: valid=0 cycles SHALL change no counter, bitmap or flag.
REQ-022 Each checked vector SHALL increment vec_count and set covered[{a,b}].
REQ-023 A failed vector (c or s differs) SHALL increment err_count and pulse mismatch on the following cycle (1-cycle latency).
REQ-024 first_err SHALL capture {a,b} only on the first failure of a session; later failures leave it unchanged.
REQ-025 err_count and vec_count SHALL saturate at all-ones, never wrap.
REQ-026 RUN: valid=1 and last=1 -> that vector is checked, then DONE next cycle.
REQ-027 RUN: start SHALL be ignored.
REQ-028 last=1 with valid=0 SHALL be ignored.
REQ-029 DONE: pass SHALL equal (err_count==0) and (covered==4'b1111); done=1, busy=0.
REQ-030 DONE: start=1 SHALL begin a new session exactly as from IDLE (clear and enter RUN); otherwise DONE holds.
REQ-031 DONE/IDLE: valid, a, b, c, s SHALL be ignored.
REQ-032 pass SHALL be 0 outside DONE.

Reset
REQ-033 rst=1 SHALL force IDLE and zero every output (busy, mismatch, done, pass, err_count, vec_count, covered, first_err) on the next edge.
REQ-034 rst SHALL dominate start, valid and last in the same cycle.
REQ-035 rst asserted mid-RUN SHALL abandon the session; no partial verdict is retained.

Verification
REQ-036 start; valid vectors {a,b,c,s} = 0000, 0101, 1001, 1110 (last on fourth) -> vec_count=4, err_count=0, covered=1111, done=1, pass=1, mismatch never high.
REQ-037 Same sequence with second vector c,s=00 -> mismatch pulses one cycle after it, err_count=1, first_err=01, pass=0.
REQ-038 Only vectors 00 and 11, both correct, last on second -> covered=1001, err_count=0, pass=0.
REQ-039 ERR_W=2, five failing vectors -> err_count saturates at 3, vec_count=5.
REQ-040 rst pulsed after two vectors in RUN -> all outputs 0, state IDLE; subsequent valid vectors without start leave vec_count=0.
REQ-041 start in DONE after a failing session -> counters and first_err cleared, busy=1 next cycle; start during RUN has no effect.
